wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin arbiter that shares one pipelined Wishbone master port between `Count` requesting masters. It sits upstream of the `wb_multiplexer` address decoder, so several bus masters (CPU fetch, CPU data, DMA, ...) can reach the whole slave fabric. A grant is held for the full `cyc` cycle of the winning master. Non-granted masters see a stalled bus.

## Interface

Parameters:
- `Count`, 2, number of requesting masters; must be ≥ 2.
- `DataWidth`, 32, data bus width.
- `AddrWidth`, 32, address bus width.
- `SelWidth`, `DataWidth/8` (localparam), byte-select width.
- `IdxWidth`, `$clog2(Count)` (localparam), grant index width.

Ports:
- Clocking and reset:
  - `clk`  in  1  single clock; everything is on its rising edge.
  - `reset`  in  1  synchronous, active-high reset.
- Master side, per requester (unpacked arrays `[Count]`):
  - `m_data_m`  in  DataWidth  write data.
  - `m_addr`  in  AddrWidth  address.
  - `m_sel`  in  SelWidth  byte selects.
  - `m_cyc`  in  1  bus request and cycle.
  - `m_stb`  in  1  strobe.
  - `m_we`  in  1  write enable.
  - `m_data_s`  out  DataWidth  read data, broadcast from `s_data_s` to all requesters.
  - `m_ack`  out  1  acknowledge, granted master only.
  - `m_stall`  out  1  stall; forced 1 for every non-granted master.
  - `m_err`  out  1  error, granted master only.
- Shared side, toward the multiplexer:
  - `s_data_m`  out  DataWidth  write data.
  - `s_addr`  out  AddrWidth  address.
  - `s_sel`  out  SelWidth  byte selects.
  - `s_cyc`  out  1  cycle.
  - `s_stb`  out  1  strobe.
  - `s_we`  out  1  write enable.
  - `s_data_s`  in  DataWidth  read data.
  - `s_ack`  in  1  acknowledge.
  - `s_stall`  in  1  stall.
  - `s_err`  in  1  error.
- Status:
  - `grant_valid`  out  1  a master currently owns the bus.
  - `grant_idx`  out  IdxWidth  index of the owner; valid when `grant_valid` is 1.

## Operation

- State is two registers:
  - `grant_valid`, reset 0.
  - `grant_idx`, reset 0.
- One additional register, `last_idx`, reset `Count-1`, so master 0 has first priority after reset.
- **IDLE** (`grant_valid`=0):
  - At each edge, if any `m_cyc[i]`=1, pick the winner round-robin.
  - Search starts at `(last_idx+1) mod Count` and ascends with wrap-around; the first `i` with `m_cyc[i]`=1 wins.
  - On that edge: set `grant_valid`=1, `grant_idx`=winner, `last_idx`=winner.
- **GRANTED** (`grant_valid`=1, owner g):
  - Request path to the shared side: `s_cyc`=`m_cyc[g]`, `s_stb`=`m_stb[g]`; `s_addr`, `s_data_m`, `s_sel`, `s_we` come from master g.
  - Response path to master g: `m_ack[g]`=`s_ack`, `m_err[g]`=`s_err`, `m_stall[g]`=`s_stall`.
  - All other masters: ack=0, err=0, stall=1.
- **Release**: on an edge where `m_cyc[g]`=0, the owner gives up the bus.
  - If another request is pending, arbitration runs on that same edge, with g now treated as `last_idx`, so the new owner is granted with zero dead cycles.
  - Otherwise go to IDLE.
- **Abort**: an owner dropping `cyc` with transactions outstanding aborts them. The arbiter keeps no transaction count; late acks arriving after handover are routed to the new owner. Slaves must honour Wishbone abort semantics.
- **Outputs in IDLE or reset**:
  - `s_cyc`=0 and `s_stb`=0.
  - `s_addr`, `s_data_m`, `s_sel`, `s_we` carry master `grant_idx`'s values (don't-care).
  - All `m_stall`=1, all `m_ack`=0, all `m_err`=0.
- **Reset**:
  - `reset` forces IDLE at the next edge regardless of bus activity.
  - The combinational outputs follow the registers, so from the cycle after the reset edge `s_cyc`=0 and all masters are stalled.

## Timing

- Request to grant: 1 cycle. A master raising `m_cyc` in cycle t sees `s_cyc`=1 and `m_stall` equal to `s_stall` from cycle t+1.
- Data and response paths are purely combinational; the arbiter adds no pipeline latency.
- Release takes effect combinationally: `s_cyc` falls in the same cycle as `m_cyc[g]`. The next owner drives from the following cycle.
- If a master asserts `m_stb` while not granted, it is stalled and must hold its request per Wishbone; nothing is lost.
- Simultaneous requests are resolved only by round-robin order; there is no fixed priority.

## Test plan

1. **Reset**: assert `reset` for 2 cycles with `m_cyc[0]`=1.
   - During reset: `s_cyc`=0 and `m_stall[0]`=1.
   - First edge after deassert: `grant_idx`=0, and the cycle after, `s_cyc`=1.
2. **Single master, two writes**: master 1 issues writes to 0x10 and 0x14 with `s_stall`=0 and slave ack one cycle later.
   - Both addresses appear on `s_addr` in consecutive cycles.
   - `m_ack[1]` pulses twice; `m_stall[0]` stays 1 throughout.
3. **Round-robin fairness**: `Count`=4, all `m_cyc` held high, each master drops `cyc` after one transaction and then re-requests.
   - Grant order is 0,1,2,3,0,1 with no dead cycles between owners.
4. **Stall passthrough**: owner 2 with `s_stall`=1 for 3 cycles.
   - `m_stall[2]`=1 for exactly those cycles.
   - The `s_stb` address stays held; the beat is accepted on the 4th cycle.
5. **Zero-gap handover**: master 0 owns the bus, master 3 is waiting, and master 0 drops `cyc` in cycle t.
   - `s_cyc`=0 in cycle t.
   - `grant_idx`=3 and `s_cyc`=1 in cycle t+1.
6. **Reset mid-burst**: assert `reset` while master 1 is granted with `s_stb`=1.
   - Next cycle: `grant_valid`=0, `s_cyc`=0, all `m_ack`=0.
   - After release, the first grant goes to the lowest-index pending master.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Wishbone pipelined bus bundle. Every signal is an unpacked array of
// Ports lanes so one definition serves both the multi-requester side
// (Ports = Count) and the single shared side (Ports = 1).
interface wb_arbiter_if #(
    parameter int Ports     = 1,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    localparam int SelWidth = DataWidth / 8;

    logic [DataWidth-1:0] data_m [Ports];
    logic [AddrWidth-1:0] addr   [Ports];
    logic [SelWidth-1:0]  sel    [Ports];
    logic                 cyc    [Ports];
    logic                 stb    [Ports];
    logic                 we     [Ports];
    logic [DataWidth-1:0] data_s [Ports];
    logic                 ack    [Ports];
    logic                 stall  [Ports];
    logic                 err    [Ports];

    // Bus initiator view: drives the request, receives the response.
    modport master (
        output data_m, addr, sel, cyc, stb, we,
        input  data_s, ack, stall, err
    );

    // Bus target view: receives the request, drives the response.
    modport slave (
        input  data_m, addr, sel, cyc, stb, we,
        output data_s, ack, stall, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master port among
// Count requesters. The owner keeps the bus for its whole cyc period;
// everyone else sees stall. Request and response paths are purely
// combinational, only the ownership state is registered.
module wb_arbiter #(
    parameter int  Count     = 2,
    parameter int  DataWidth = 32,
    parameter int  AddrWidth = 32,
    localparam int SelWidth  = DataWidth / 8,
    localparam int IdxWidth  = $clog2(Count)
) (
    input  logic                clk,
    input  logic                reset,
    wb_arbiter_if.slave         m_bus,
    wb_arbiter_if.master        s_bus,
    output logic                grant_valid,
    output logic [IdxWidth-1:0] grant_idx
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] grant_idx_q, grant_idx_d;
    logic [IdxWidth-1:0] last_idx_q, last_idx_d;

    logic                req_found;
    logic [IdxWidth-1:0] winner;
    logic                owner_active;

    logic [DataWidth-1:0] data_mux;
    logic [AddrWidth-1:0] addr_mux;
    logic [SelWidth-1:0]  sel_mux;

    assign owner_active = (state_q == GRANTED);
    assign grant_valid  = owner_active;
    assign grant_idx    = grant_idx_q;

    // Round-robin search: first requester after last_idx, wrapping around.
    always_comb begin : rr_search
        int                  cand;
        logic [IdxWidth-1:0] cand_idx;
        req_found = 1'b0;
        winner    = last_idx_q;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= Count; k++) begin
            cand     = (int'(last_idx_q) + k) % Count;
            cand_idx = IdxWidth'(cand);
            if (!req_found && m_bus.cyc[cand_idx]) begin
                req_found = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    // Ownership next state: arbitrate when idle or on the owner's release
    // edge, so a waiting master takes over with no dead cycle.
    always_comb begin : next_state
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        if (state_q == IDLE || !m_bus.cyc[grant_idx_q]) begin
            if (req_found) begin
                state_d     = GRANTED;
                grant_idx_d = winner;
                last_idx_d  = winner;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Ownership registers; last_idx resets to Count-1 so master 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= IdxWidth'(Count - 1);
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
        end
    end

    // Request path: the owner's signals go to the shared port; cyc/stb are
    // gated so the shared port is quiet while nobody owns the bus.
    always_comb begin : request_mux
        data_mux = m_bus.data_m[grant_idx_q];
        addr_mux = m_bus.addr[grant_idx_q];
        sel_mux  = m_bus.sel[grant_idx_q];

        s_bus.data_m[0] = data_mux;
        s_bus.addr[0]   = addr_mux;
        s_bus.sel[0]    = sel_mux;
        s_bus.we[0]     = m_bus.we[grant_idx_q];
        s_bus.cyc[0]    = owner_active & m_bus.cyc[grant_idx_q];
        s_bus.stb[0]    = owner_active & m_bus.stb[grant_idx_q];
    end

    // Response path: read data is broadcast, handshake goes to the owner only.
    for (genvar i = 0; i < Count; i++) begin : g_resp
        logic is_owner;
        assign is_owner          = owner_active && (grant_idx_q == IdxWidth'(i));
        assign m_bus.data_s[i]   = s_bus.data_s[0];
        assign m_bus.ack[i]      = is_owner & s_bus.ack[0];
        assign m_bus.err[i]      = is_owner & s_bus.err[0];
        assign m_bus.stall[i]    = is_owner ? s_bus.stall[0] : 1'b1;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter with four requesters. Stimulus pushes the
// expected combinational response for each cycle; a monitor pops and
// compares on the falling edge.
module tb_wb_arbiter;
    localparam int Count     = 4;
    localparam int DataWidth = 32;
    localparam int AddrWidth = 32;
    localparam int SelWidth  = DataWidth / 8;
    localparam int IdxWidth  = $clog2(Count);

    logic                clk = 1'b0;
    logic                reset;
    logic                grant_valid;
    logic [IdxWidth-1:0] grant_idx;

    always #5 clk = ~clk;

    wb_arbiter_if #(.Ports(Count), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) m_if ();
    wb_arbiter_if #(.Ports(1),     .DataWidth(DataWidth), .AddrWidth(AddrWidth)) s_if ();

    wb_arbiter #(
        .Count(Count), .DataWidth(DataWidth), .AddrWidth(AddrWidth)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_bus(m_if),
        .s_bus(s_if),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );

    // Per-cycle drive values
    logic                 rst_v;
    logic [Count-1:0]     cyc_v, stb_v, we_v;
    logic [AddrWidth-1:0] addr_v [Count];
    logic [DataWidth-1:0] data_v [Count];
    logic [SelWidth-1:0]  sel_v  [Count];
    logic                 sack_v, sstall_v, serr_v;
    logic [DataWidth-1:0] sdata_v;

    typedef struct {
        logic                 gv;
        logic [IdxWidth-1:0]  gi;
        logic                 s_cyc, s_stb, s_we;
        logic [AddrWidth-1:0] s_addr;
        logic [DataWidth-1:0] s_data_m, s_data_s;
        logic [SelWidth-1:0]  s_sel;
        logic [Count-1:0]     ack, stall, err;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: who owns the bus and who was served last
    bit mdl_valid;
    int mdl_owner;
    int mdl_last;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    endtask

    // Ownership rule: release/idle picks the requester closest after last served.
    task automatic model_edge();
        int best, best_dist, d;
        if (rst_v) begin
            mdl_valid = 0; mdl_owner = 0; mdl_last = Count - 1;
        end else if (!mdl_valid || !cyc_v[mdl_owner]) begin
            best = -1; best_dist = Count;
            for (int i = 0; i < Count; i++) begin
                if (cyc_v[i]) begin
                    d = (i - mdl_last - 1 + 2 * Count) % Count;
                    if (d < best_dist) begin best_dist = d; best = i; end
                end
            end
            if (best >= 0) begin
                mdl_valid = 1; mdl_owner = best; mdl_last = best;
            end else begin
                mdl_valid = 0;
            end
        end
    endtask

    task automatic rand_payload();
        for (int i = 0; i < Count; i++) begin
            addr_v[i] = $urandom;
            data_v[i] = $urandom;
            sel_v[i]  = SelWidth'($urandom);
        end
        we_v    = Count'($urandom);
        sdata_v = $urandom;
    endtask

    // Apply one cycle of inputs, record what the bus must show, advance.
    task automatic step();
        exp_t e;
        reset = rst_v;
        for (int i = 0; i < Count; i++) begin
            m_if.cyc[i]    = cyc_v[i];
            m_if.stb[i]    = stb_v[i];
            m_if.we[i]     = we_v[i];
            m_if.addr[i]   = addr_v[i];
            m_if.data_m[i] = data_v[i];
            m_if.sel[i]    = sel_v[i];
        end
        s_if.ack[0]    = sack_v;
        s_if.stall[0]  = sstall_v;
        s_if.err[0]    = serr_v;
        s_if.data_s[0] = sdata_v;

        e.gv       = mdl_valid;
        e.gi       = IdxWidth'(mdl_owner);
        e.s_cyc    = mdl_valid && cyc_v[mdl_owner];
        e.s_stb    = mdl_valid && stb_v[mdl_owner];
        e.s_we     = we_v[mdl_owner];
        e.s_addr   = addr_v[mdl_owner];
        e.s_data_m = data_v[mdl_owner];
        e.s_sel    = sel_v[mdl_owner];
        e.s_data_s = sdata_v;
        e.ack      = '0;
        e.err      = '0;
        e.stall    = '1;
        if (mdl_valid) begin
            e.ack[mdl_owner]   = sack_v;
            e.err[mdl_owner]   = serr_v;
            e.stall[mdl_owner] = sstall_v;
        end
        exp_q.push_back(e);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stb_v = '0; sack_v = 0; sstall_v = 0; serr_v = 0;
    endtask

    // Monitor: compare every presented cycle against the scoreboard entry.
    initial begin : monitor
        exp_t             e;
        logic [Count-1:0] ack_a, stall_a, err_a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < Count; i++) begin
                    ack_a[i]   = m_if.ack[i];
                    stall_a[i] = m_if.stall[i];
                    err_a[i]   = m_if.err[i];
                end
                chk("grant_valid", 64'(grant_valid), 64'(e.gv));
                chk("grant_idx", 64'(grant_idx), 64'(e.gi));
                chk("s_cyc", 64'(s_if.cyc[0]), 64'(e.s_cyc));
                chk("s_stb", 64'(s_if.stb[0]), 64'(e.s_stb));
                if (e.s_cyc) begin
                    chk("s_addr", 64'(s_if.addr[0]), 64'(e.s_addr));
                    chk("s_data_m", 64'(s_if.data_m[0]), 64'(e.s_data_m));
                    chk("s_sel", 64'(s_if.sel[0]), 64'(e.s_sel));
                    chk("s_we", 64'(s_if.we[0]), 64'(e.s_we));
                end
                chk("m_ack", 64'(ack_a), 64'(e.ack));
                chk("m_stall", 64'(stall_a), 64'(e.stall));
                chk("m_err", 64'(err_a), 64'(e.err));
                for (int i = 0; i < Count; i++)
                    chk("m_data_s", 64'(m_if.data_s[i]), 64'(e.s_data_s));
            end
        end
    end

    initial begin : stimulus
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};

        rst_v = 1; cyc_v = '0; quiet(); rand_payload();
        reset = 1;
        for (int i = 0; i < Count; i++) begin
            m_if.cyc[i] = 0; m_if.stb[i] = 0; m_if.we[i] = 0;
            m_if.addr[i] = '0; m_if.data_m[i] = '0; m_if.sel[i] = '0;
        end
        s_if.ack[0] = 0; s_if.stall[0] = 0; s_if.err[0] = 0; s_if.data_s[0] = '0;
        mdl_valid = 0; mdl_owner = 0; mdl_last = Count - 1;
        @(posedge clk);
        #1;

        // Reset held with master 0 requesting, then first grant
        cyc_v = 4'b0001;
        step(); step();
        rst_v = 0;
        step(); step(); step();
        cyc_v = '0; step();

        // Master 1: two pipelined writes, ack one cycle behind
        rst_v = 1; step(); rst_v = 0;
        cyc_v = 4'b0010; step();
        stb_v = 4'b0010; we_v = 4'b0010; addr_v[1] = 32'h10; sack_v = 0; step();
        addr_v[1] = 32'h14; data_v[1] = $urandom; sack_v = 1; step();
        stb_v = '0; sack_v = 1; step();
        sack_v = 0; cyc_v = '0; step();

        // Round-robin with everyone requesting
        rst_v = 1; step(); rst_v = 0;
        quiet(); cyc_v = '1; step();
        for (int k = 0; k < 6; k++) begin
            chk("rr_valid", 64'(grant_valid), 64'(1));
            chk("rr_order", 64'(grant_idx), 64'(exp_order[k]));
            rand_payload();
            stb_v = '0; stb_v[mdl_owner] = 1; sack_v = 1; step();
            stb_v = '0; sack_v = 0; cyc_v = '1; cyc_v[mdl_owner] = 0; step();
            cyc_v = '1;
        end
        cyc_v = '0; step();

        // Stall passthrough on owner 2
        rst_v = 1; step(); rst_v = 0;
        quiet(); cyc_v = 4'b0100; step();
        stb_v = 4'b0100; addr_v[2] = 32'hA0; sstall_v = 1;
        step(); step(); step();
        sstall_v = 0; step();
        stb_v = '0; sack_v = 1; step();
        quiet(); cyc_v = '0; step();

        // Zero-gap handover from master 0 to waiting master 3
        rst_v = 1; step(); rst_v = 0;
        cyc_v = 4'b1001; step();
        stb_v = 4'b0001; sack_v = 1; step();
        quiet(); cyc_v = 4'b1000; step();
        step();
        chk("handover_idx", 64'(grant_idx), 64'(3));
        cyc_v = '0; step();

        // Reset mid-burst, then lowest pending index wins
        cyc_v = 4'b0010; step();
        stb_v = 4'b0010; step();
        rst_v = 1; cyc_v = 4'b1010; sack_v = 1; step();
        rst_v = 0; quiet(); step();
        step();
        cyc_v = '0; step();

        // Randomized traffic with occasional reset
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < Count; i++)
                if ($urandom_range(0, 3) == 0) cyc_v[i] = ~cyc_v[i];
            rand_payload();
            stb_v    = Count'($urandom);
            sack_v   = 1'($urandom_range(0, 1));
            sstall_v = 1'($urandom_range(0, 1));
            serr_v   = ($urandom_range(0, 7) == 0);
            rst_v    = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_v = 0; cyc_v = '0; quiet(); step();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
